// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, reads instruction words over a single-cycle
// ready handshake, and presents the captured instruction register to decode.
// Supports branch/jump redirects and stops fetching after a HALT opcode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        out_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [5:0]  op_code,
  output logic [5:0]  func_code,
  output logic [15:0] imm16,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        vld_q, vld_d;
  logic        halted_q, halted_d;
  logic [31:0] redirect_aligned;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  // State and datapath registers; reset returns everything to the power-on view.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0;
      pc_out_q <= 32'h0;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pc_out_q <= pc_out_d;
      vld_q    <= vld_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic: a redirect beats both the memory and decode handshakes.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    vld_d    = vld_q;
    halted_d = halted_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = redirect_aligned;
        state_d = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          // Any word returned this cycle belongs to the abandoned path.
          pc_d     = redirect_aligned;
          vld_d    = 1'b0;
          halted_d = 1'b0;
          state_d  = REQ;
        end else if (imem_ready) begin
          ir_d     = imem_rdata;
          pc_out_d = pc_q;
          pc_d     = pc_q + 32'd4;
          vld_d    = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d     = redirect_aligned;
          vld_d    = 1'b0;
          halted_d = 1'b0;
          state_d  = REQ;
        end else if (out_ready) begin
          vld_d = 1'b0;
          if (ir_q[31:26] == HALT_OP) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            state_d = REQ;
          end
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          pc_d     = redirect_aligned;
          vld_d    = 1'b0;
          halted_d = 1'b0;
          state_d  = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory request is only qualified in REQ; the address always follows the PC.
  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = vld_q;
  assign instr_out   = ir_q;
  assign pc_out      = pc_out_q;
  assign halted      = halted_q;

  // Decode-facing fields are plain slices of the instruction register.
  assign op_code   = ir_q[31:26];
  assign func_code = ir_q[5:0];
  assign imm16     = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized handshakes/redirects/resets, all checked every cycle
// against a transaction-level model of the fetch behaviour.
module tb_instr_fetch_unit;

  localparam logic [5:0] HALT = 6'b111111;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [5:0]  op_code;
  logic [5:0]  func_code;
  logic [15:0] imm16;
  logic        halted;

  int checks;
  int failures;

  // Model state: what the fetch unit must be showing after each edge.
  logic [31:0] m_pc, m_ir, m_pcout;
  logic        m_valid, m_halted, m_fetching, m_fresh;
  logic        halt_en;

  instr_fetch_unit #(.RESET_PC(32'h0), .HALT_OP(HALT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_ready(out_ready),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
    .op_code(op_code), .func_code(func_code), .imm16(imm16), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-tagged memory contents; a HALT word sits where addr[6:2]==7 when enabled.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    op = {1'b0, a[6:2]};
    if (halt_en && a[6:2] == 5'd7) op = HALT;
    return {op, a[25:0] ^ 26'h1A55AA5};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs that the DUT will see.
  task automatic model_step(input logic rdy, input logic ordy, input logic rv,
                            input logic [31:0] rpc, input logic r);
    logic [31:0] tgt;
    tgt = {rpc[31:2], 2'b00};
    if (r) begin
      m_pc = 32'h0; m_ir = 32'h0; m_pcout = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_fetching = 1'b0; m_fresh = 1'b1;
    end else if (m_fresh) begin
      m_fresh = 1'b0;
      if (rv) m_pc = tgt;
      m_fetching = 1'b1;
    end else if (rv) begin
      m_pc = tgt; m_valid = 1'b0; m_halted = 1'b0; m_fetching = 1'b1;
    end else if (m_fetching && rdy) begin
      m_ir = mem_word(m_pc); m_pcout = m_pc; m_pc = m_pc + 32'd4;
      m_valid = 1'b1; m_fetching = 1'b0;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
      if (m_ir[31:26] == HALT) m_halted = 1'b1;
      else m_fetching = 1'b1;
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    chk("imem_req", {31'h0, imem_req}, {31'h0, m_fetching});
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
    chk("halted", {31'h0, halted}, {31'h0, m_halted});
    chk("instr_out", instr_out, m_ir);
    chk("pc_out", pc_out, m_pcout);
    chk("op_code", {26'h0, op_code}, {26'h0, m_ir[31:26]});
    chk("func_code", {26'h0, func_code}, {26'h0, m_ir[5:0]});
    chk("imm16", {16'h0, imm16}, {16'h0, m_ir[15:0]});
  endtask

  // One clock: drive inputs at the falling edge, let the DUT clock, check at the next falling edge.
  task automatic cyc(input logic rdy, input logic ordy, input logic rv,
                     input logic [31:0] rpc, input logic r);
    rst = r; imem_ready = rdy; out_ready = ordy;
    redirect_valid = rv; redirect_pc = rpc;
    imem_rdata = mem_word(m_pc);
    model_step(rdy, ordy, rv, rpc, r);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    checks = 0; failures = 0; halt_en = 1'b0;
    rst = 1'b1; imem_ready = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rdata = 32'h0;
    m_pc = 32'h0; m_ir = 32'h0; m_pcout = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_fetching = 1'b0; m_fresh = 1'b1;

    // Reset state
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 1, 32'h40, 1);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_ir", instr_out, 32'h0);
    chk("rst_pc", imem_addr, 32'h0);

    // Scenario 1: memory always ready, decode always ready
    cyc(1, 1, 0, 32'h0, 0);
    chk("s1_req0", {31'h0, imem_req}, 32'h1);
    chk("s1_addr0", imem_addr, 32'h0);
    cyc(1, 1, 0, 32'h0, 0);
    chk("s1_valid0", {31'h0, instr_valid}, 32'h1);
    chk("s1_pcout0", pc_out, 32'h0);
    chk("s1_ir0", instr_out, 32'h01A55AA5);
    cyc(1, 1, 0, 32'h0, 0);
    chk("s1_addr1", imem_addr, 32'h4);
    chk("s1_valid_gap", {31'h0, instr_valid}, 32'h0);
    cyc(1, 1, 0, 32'h0, 0);
    chk("s1_pcout1", pc_out, 32'h4);
    chk("s1_ir1", instr_out, 32'h05A55AA1);
    cyc(1, 1, 0, 32'h0, 0);
    chk("s1_addr2", imem_addr, 32'h8);

    // Scenario 2: memory stalls three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 32'h0, 0);
      chk("s2_addr_hold", imem_addr, 32'h8);
      chk("s2_nvalid", {31'h0, instr_valid}, 32'h0);
    end
    cyc(1, 0, 0, 32'h0, 0);
    chk("s2_pcout", pc_out, 32'h8);

    // Scenario 3: decode back-pressure for five cycles
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 32'h0, 0);
      chk("s3_hold_valid", {31'h0, instr_valid}, 32'h1);
      chk("s3_no_req", {31'h0, imem_req}, 32'h0);
      chk("s3_pcout", pc_out, 32'h8);
    end
    cyc(0, 1, 0, 32'h0, 0);

    // Scenario 4: redirect coincides with returned word
    cyc(1, 0, 1, 32'h103, 0);
    chk("s4_addr", imem_addr, 32'h100);
    chk("s4_valid", {31'h0, instr_valid}, 32'h0);
    chk("s4_pcout_kept", pc_out, 32'h8);

    // Scenario 5: HALT consumed, then redirect restarts fetch
    halt_en = 1'b1;
    cyc(0, 0, 1, 32'h1C, 0);
    cyc(1, 0, 0, 32'h0, 0);
    chk("s5_op", {26'h0, op_code}, {26'h0, HALT});
    cyc(0, 1, 0, 32'h0, 0);
    chk("s5_halted", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 32'h0, 0);
      chk("s5_no_req", {31'h0, imem_req}, 32'h0);
    end
    cyc(0, 0, 1, 32'h40, 0);
    chk("s5_unhalt", {31'h0, halted}, 32'h0);
    chk("s5_req", {31'h0, imem_req}, 32'h1);
    chk("s5_addr", imem_addr, 32'h40);

    // Scenario 6: PC wrap, then reset while holding
    cyc(0, 0, 1, 32'hFFFF_FFFF, 0);
    cyc(1, 0, 0, 32'h0, 0);
    chk("s6_pcout", pc_out, 32'hFFFF_FFFC);
    chk("s6_wrap", imem_addr, 32'h0);
    cyc(0, 0, 0, 32'h0, 1);
    chk("s6_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("s6_rst_ir", instr_out, 32'h0);
    chk("s6_rst_pcout", pc_out, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic r, rv, rdy, ordy;
      logic [31:0] rpc;
      r    = ($urandom_range(0, 199) == 0);
      rv   = ($urandom_range(0, 11) == 0);
      rdy  = ($urandom_range(0, 1) == 1);
      ordy = ($urandom_range(0, 9) < 6);
      rpc  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      cyc(rdy, ordy, rv, rpc, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
